// File: rtl/rca_sum_accumulator_if.sv
// rca_sum_accumulator_if: batch control, beat input and result output
// bundle between an adder-result producer and the accumulator.
interface rca_sum_accumulator_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
);
  logic              start;
  logic [CNT_W-1:0]  num_samples;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sum_in;
  logic              c_out_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic              busy;

  modport master (
    output start, num_samples, in_valid,
    output sum_in, c_out_in, out_ready,
    input  in_ready, out_valid, acc_out,
    input  overflow, busy
  );

  modport slave (
    input  start, num_samples, in_valid,
    input  sum_in, c_out_in, out_ready,
    output in_ready, out_valid, acc_out,
    output overflow, busy
  );
endinterface

// File: rtl/rca_sum_accumulator.sv
// rca_sum_accumulator: sums a batch of {C_out,Sum_out} beats into ACC_W bits.
// Define RCA_ACC_SATURATE_EN to clamp at 2^ACC_W-1 instead of wrapping.
module rca_sum_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rca_sum_accumulator_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   operand;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             beat;

  assign operand = (ACC_W+1)'({bus.c_out_in, bus.sum_in});
  assign sum     = {1'b0, acc} + operand;
  assign beat    = bus.in_valid && (state == ACCUM);

`ifdef RCA_ACC_SATURATE_EN
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.acc_out   = acc;
  assign bus.overflow  = ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= bus.num_samples;
            if (bus.num_samples == '0)
              state <= DONE;
            else
              state <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= acc_nxt;
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
              state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
